// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan states and segment patterns for the 7-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {BLANK0, DIG0, BLANK1, DIG1} state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Bit order {g,f,e,d,c,b,a}; 'b' and 'd' are lower-case glyphs.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: count bus from the counter stage (value, load strobe, hold).
interface seg7_scan_driver_if;

    logic [7:0] value;
    logic       load;
    logic       hold;

    modport master (output value, load, hold);
    modport slave  (input  value, load, hold);

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to 7-segment pattern lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: two-digit multiplexed hex display with tear-free frame-boundary updates.
// Define SEG7_LZB_EN to blank the high digit when its nibble is zero.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 1024,
    parameter int BLANK_CYCLES   = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   cnt_i,
    output logic [6:0]          seg_o,
    output logic                dp_o,
    output logic [1:0]          dig_o,
    output logic                frame_o
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int PW   = $clog2(MAXC);
    localparam logic [PW-1:0] DIG_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [7:0]    disp_q, disp_d, pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [6:0]    seg_q, seg_d, hex;
    logic          dp_q, dp_d, frame_q, frame_d;
    logic [1:0]    dig_q, dig_d;
    logic          done, xfer, hi_blank;

    hex_to_seg7 u_hex (
        .nib_i (state_q == DIG1 ? disp_q[7:4] : disp_q[3:0]),
        .seg_o (hex)
    );

`ifdef SEG7_LZB_EN
    assign hi_blank = (disp_q[7:4] == 4'h0);
`else
    assign hi_blank = 1'b0;
`endif

    always_comb begin
        done     = cnt_q == ((state_q == DIG0 || state_q == DIG1) ? DIG_LAST : BLANK_LAST);
        state_d  = done ? state_e'(state_q + 2'd1) : state_q;
        cnt_d    = done ? '0 : cnt_q + 1'b1;
        frame_d  = (state_q == DIG1) && done;
        xfer     = frame_d && pend_v_q && !cnt_i.hold;
        disp_d   = xfer ? pend_q : disp_q;
        pend_d   = cnt_i.load ? cnt_i.value : pend_q;
        pend_v_d = cnt_i.load || (pend_v_q && !xfer);
        seg_d    = (state_q == DIG0 || (state_q == DIG1 && !hi_blank)) ? hex : SEG_OFF;
        dig_d    = {state_q == DIG1, state_q == DIG0};
        dp_d     = (state_q == DIG0) && cnt_i.hold;
    end

    // Polarity is folded into the output flops so reset shows everything dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BLANK0;
            cnt_q    <= '0;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            seg_q    <= {7{ACTIVE_LOW_SEG}};
            dp_q     <= ACTIVE_LOW_SEG;
            dig_q    <= {2{ACTIVE_LOW_SEG}};
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            seg_q    <= seg_d ^ {7{ACTIVE_LOW_SEG}};
            dp_q     <= dp_d ^ ACTIVE_LOW_SEG;
            dig_q    <= dig_d ^ {2{ACTIVE_LOW_SEG}};
            frame_q  <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign dig_o   = dig_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, tear-free capture, hold and reset.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg;
    logic       dp, frame;
    logic [1:0] dig;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV    (4),
        .BLANK_CYCLES   (1),
        .ACTIVE_LOW_SEG (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_i   (bus.slave),
        .seg_o   (seg),
        .dp_o    (dp),
        .dig_o   (dig),
        .frame_o (frame)
    );

    always #5 clk = ~clk;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] HI_ZERO = 7'h00;
`else
    localparam logic [6:0] HI_ZERO = 7'h3F;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic digit(input string tag, input int n, input logic [1:0] d, input logic [6:0] s);
        goto(n);
        chk({tag, "_dig"}, 16'(dig), 16'(d));
        chk({tag, "_seg"}, 16'(seg), 16'(s));
    endtask

    initial begin
        bus.value = '0;
        bus.load  = 1'b0;
        bus.hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 16'(seg), 16'h0);
        chk("rst_dig", 16'(dig), 16'h0);
        chk("rst_frame", 16'(frame), 16'h0);
        chk("rst_dp", 16'(dp), 16'h0);
        release_rst();
        goto(1);
        chk("blank0_dig", 16'(dig), 16'h0);
        digit("f0_d0", 2, 2'b01, 7'h3F);
        goto(3);
        do_load(8'hA5);
        digit("f0_d1_tearfree", 7, 2'b10, HI_ZERO);
        goto(9);
        chk("frame_pre", 16'(frame), 16'h0);
        goto(10);
        chk("frame_pulse", 16'(frame), 16'h1);
        goto(11);
        chk("frame_post", 16'(frame), 16'h0);
        digit("a5_lo", 12, 2'b01, 7'h6D);
        digit("a5_hi", 17, 2'b10, 7'h77);
        goto(20);
        chk("frame_pulse2", 16'(frame), 16'h1);
        goto(21);
        do_load(8'h12);
        goto(24);
        do_load(8'h34);
        goto(30);
        chk("frame_pulse3", 16'(frame), 16'h1);
        digit("lastwins_lo", 32, 2'b01, 7'h66);
        do_load(8'h66);
        digit("lastwins_hi", 37, 2'b10, 7'h4F);
        goto(39);
        do_load(8'h77);
        digit("sameclk_lo", 42, 2'b01, 7'h7D);
        digit("sameclk_hi", 47, 2'b10, 7'h7D);
        digit("next_lo", 52, 2'b01, 7'h07);
        digit("next_hi", 57, 2'b10, 7'h07);
        bus.hold = 1'b1;
        do_load(8'h3C);
        digit("hold_lo", 62, 2'b01, 7'h07);
        chk("hold_dp0", 16'(dp), 16'h1);
        digit("hold_hi", 67, 2'b10, 7'h07);
        chk("hold_dp1", 16'(dp), 16'h0);
        bus.hold = 1'b0;
        digit("unhold_lo", 72, 2'b01, 7'h39);
        chk("unhold_dp", 16'(dp), 16'h0);
        do_load(8'h0F);
        digit("unhold_hi", 77, 2'b10, 7'h4F);
        digit("0f_lo", 82, 2'b01, 7'h71);
        digit("0f_hi", 87, 2'b10, HI_ZERO);
        do_load(8'h21);
        rst_n = 1'b0;
        #1;
        chk("midrst_seg", 16'(seg), 16'h0);
        chk("midrst_dig", 16'(dig), 16'h0);
        chk("midrst_frame", 16'(frame), 16'h0);
        release_rst();
        digit("post_lo", 2, 2'b01, 7'h3F);
        digit("post_hi", 7, 2'b10, HI_ZERO);
        goto(10);
        chk("post_frame", 16'(frame), 16'h1);
        digit("post_nopend", 12, 2'b01, 7'h3F);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
